// File: rtl/mips_instr_fetch.sv
// Instruction fetch front end: owns the PC, reads one word at a time from the
// instruction bus and hands it to decode, applying redirects after one delay slot.
module mips_instr_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDRESS = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] instr_address,
    output logic        instr_read,
    input  logic        instr_waitrequest,
    input  logic [31:0] instr_readdata,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        active,
    output logic        fault
);

    typedef enum logic [1:0] {
        START,
        FETCH,
        DELIVER,
        HALTED
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] target_q;
    logic        pending_q;
    logic [31:0] instr_out_q;
    logic [31:0] instr_pc_q;
    logic        read_q;
    logic        valid_q;
    logic        active_q;
    logic        fault_q;

    logic        accept;
    logic        handshake;
    logic [31:0] pc_seq_d;

    assign accept    = (state_q == FETCH) && read_q && !instr_waitrequest;
    assign handshake = (state_q == DELIVER) && valid_q && instr_ready;
    // Sequential successor wraps naturally at 2^32 and is never treated as a halt.
    assign pc_seq_d  = pc_q + 32'd4;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= START;
            pc_q        <= RESET_VECTOR;
            target_q    <= 32'd0;
            pending_q   <= 1'b0;
            instr_out_q <= 32'd0;
            instr_pc_q  <= 32'd0;
            read_q      <= 1'b0;
            valid_q     <= 1'b0;
            active_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            case (state_q)
                START: begin
                    state_q  <= FETCH;
                    active_q <= 1'b1;
                    read_q   <= 1'b1;
                end
                FETCH: begin
                    if (accept) begin
                        instr_out_q <= instr_readdata;
                        instr_pc_q  <= pc_q;
                        read_q      <= 1'b0;
                        valid_q     <= 1'b1;
                        state_q     <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (handshake) begin
                        valid_q <= 1'b0;
                        if (pending_q) begin
                            // Delay slot just retired: take the saved target, ignore any new redirect.
                            pc_q      <= target_q;
                            pending_q <= 1'b0;
                            if (target_q == HALT_ADDRESS) begin
                                state_q  <= HALTED;
                                active_q <= 1'b0;
                            end else begin
                                state_q <= FETCH;
                                read_q  <= 1'b1;
                            end
                        end else if (redirect) begin
                            if (redirect_target[1:0] != 2'b00) begin
                                fault_q  <= 1'b1;
                                active_q <= 1'b0;
                                state_q  <= HALTED;
                            end else begin
                                target_q  <= redirect_target;
                                pending_q <= 1'b1;
                                pc_q      <= pc_seq_d;
                                state_q   <= FETCH;
                                read_q    <= 1'b1;
                            end
                        end else begin
                            pc_q    <= pc_seq_d;
                            state_q <= FETCH;
                            read_q  <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    read_q   <= 1'b0;
                    valid_q  <= 1'b0;
                    active_q <= 1'b0;
                end
                default: begin
                    state_q <= HALTED;
                end
            endcase
        end
    end

    assign instr_address = pc_q;
    assign instr_read    = read_q;
    assign instr_out     = instr_out_q;
    assign instr_pc      = instr_pc_q;
    assign instr_valid   = valid_q;
    assign active        = active_q;
    assign fault         = fault_q;

endmodule
